// File: rtl/elgamal_pkg.sv
// Shared types and constants for the ElGamal datapath blocks.
package elgamal_pkg;

  localparam int unsigned DEFAULT_SIZE = 64;
  localparam int unsigned ONE          = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_MUL  = 3'd1,
    WAIT_MUL = 3'd2,
    REQ_SQR  = 3'd3,
    WAIT_SQR = 3'd4,
    STEP     = 3'd5,
    OUT      = 3'd6
  } state_t;

endpackage

// File: rtl/modular_exponentiation_if.sv
// Operand/result streams and multiplier request/response channels of the
// modular exponentiation block. slave = block view, master = environment view.
interface modular_exponentiation_if #(
  parameter int unsigned SIZE = 64
);

  logic [SIZE-1:0] in_tdata_base;
  logic [SIZE-1:0] in_tdata_exp;
  logic [SIZE-1:0] in_tdata_mod;
  logic            in_tvalid;
  logic            in_tready;

  logic [SIZE-1:0] out_tdata;
  logic            out_error;
  logic            out_tvalid;
  logic            out_tready;

  logic [SIZE-1:0] mm_a_tdata;
  logic [SIZE-1:0] mm_b_tdata;
  logic [SIZE-1:0] mm_n_tdata;
  logic            mm_tvalid;
  logic            mm_tready;

  logic [SIZE-1:0] mm_res_tdata;
  logic            mm_res_tvalid;
  logic            mm_res_tready;

  logic            busy;

  modport slave (
    input  in_tdata_base, in_tdata_exp, in_tdata_mod, in_tvalid,
    output in_tready,
    output out_tdata, out_error, out_tvalid,
    input  out_tready,
    output mm_a_tdata, mm_b_tdata, mm_n_tdata, mm_tvalid,
    input  mm_tready,
    input  mm_res_tdata, mm_res_tvalid,
    output mm_res_tready,
    output busy
  );

  modport master (
    output in_tdata_base, in_tdata_exp, in_tdata_mod, in_tvalid,
    input  in_tready,
    input  out_tdata, out_error, out_tvalid,
    output out_tready,
    input  mm_a_tdata, mm_b_tdata, mm_n_tdata, mm_tvalid,
    output mm_tready,
    output mm_res_tdata, mm_res_tvalid,
    input  mm_res_tready,
    input  busy
  );

endinterface

// File: rtl/modular_exponentiation.sv
// Right-to-left square-and-multiply exponentiation; every product is
// delegated to an external modular multiplier over the mm_* channels.
module modular_exponentiation
  import elgamal_pkg::*;
#(
  parameter int unsigned SIZE = DEFAULT_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  modular_exponentiation_if.slave   bus
);

  state_t          state;
  state_t          state_nx;
  logic [SIZE-1:0] r;
  logic [SIZE-1:0] b;
  logic [SIZE-1:0] e;
  logic [SIZE-1:0] n;
  logic            err;
  logic            trivial;

  // Degenerate moduli and a zero exponent finish without touching the multiplier.
  assign trivial = (bus.in_tdata_mod == '0) || (bus.in_tdata_mod == SIZE'(ONE)) ||
                   (bus.in_tdata_exp == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (bus.in_tvalid) state_nx = trivial ? OUT : STEP;
      STEP:     state_nx = e[0] ? REQ_MUL : REQ_SQR;
      REQ_MUL:  if (bus.mm_tready) state_nx = WAIT_MUL;
      WAIT_MUL: if (bus.mm_res_tvalid) state_nx = ((e >> 1) == '0) ? OUT : REQ_SQR;
      REQ_SQR:  if (bus.mm_tready) state_nx = WAIT_SQR;
      WAIT_SQR: if (bus.mm_res_tvalid) state_nx = STEP;
      OUT:      if (bus.out_tready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Operand registers: load on accept, absorb products in the wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r   <= '0;
      b   <= '0;
      e   <= '0;
      n   <= '0;
      err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_tvalid) begin
          b   <= bus.in_tdata_base;
          e   <= bus.in_tdata_exp;
          n   <= bus.in_tdata_mod;
          err <= (bus.in_tdata_mod == '0);
          // mod 0 and mod 1 both yield 0; every other case starts from 1.
          r   <= ((bus.in_tdata_mod == '0) || (bus.in_tdata_mod == SIZE'(ONE))) ?
                 '0 : SIZE'(ONE);
        end
        WAIT_MUL: if (bus.mm_res_tvalid) r <= bus.mm_res_tdata;
        WAIT_SQR: if (bus.mm_res_tvalid) begin
          b <= bus.mm_res_tdata;
          e <= e >> 1;
        end
        default: ;
      endcase
    end
  end

  // Handshake and datapath outputs decoded from state.
  always_comb begin
    bus.in_tready     = (state == IDLE) && !rst;
    bus.mm_tvalid     = (state == REQ_MUL) || (state == REQ_SQR);
    bus.mm_a_tdata    = (state == REQ_MUL) ? r : b;
    bus.mm_b_tdata    = b;
    bus.mm_n_tdata    = n;
    bus.mm_res_tready = (state == WAIT_MUL) || (state == WAIT_SQR);
    bus.out_tvalid    = (state == OUT);
    bus.out_tdata     = r;
    bus.out_error     = err;
    bus.busy          = (state != IDLE);
  end

endmodule

// File: tb/tb_modular_exponentiation.sv
// Directed-vector bench for modular_exponentiation with a behavioural
// modular multiplier on the mm_* channels.
module tb_modular_exponentiation;

  localparam int unsigned SIZE = 64;

  logic clk;
  logic rst;

  modular_exponentiation_if #(.SIZE(SIZE)) bus ();

  modular_exponentiation #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // multiplier model state
  bit              rand_mm    = 1'b0;
  bit              pending    = 1'b0;
  bit              last_sq    = 1'b0;
  logic [SIZE-1:0] pend_res   = '0;
  int unsigned     delay      = 0;
  int unsigned     mm_reqs    = 0;
  int unsigned     rdy_viol   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SIZE-1:0] got,
                       input logic [SIZE-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [SIZE-1:0] modmul(input logic [SIZE-1:0] a,
                                             input logic [SIZE-1:0] b,
                                             input logic [SIZE-1:0] n);
    logic [2*SIZE-1:0] p;
    if (n == '0) return '0;
    p = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};
    return SIZE'(p % {{SIZE{1'b0}}, n});
  endfunction

  function automatic logic [SIZE-1:0] gold(input logic [SIZE-1:0] base,
                                           input logic [SIZE-1:0] ex,
                                           input logic [SIZE-1:0] m);
    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] sq;
    if (m == '0 || m == 64'd1) return '0;
    acc = 64'd1;
    sq  = modmul(base, 64'd1, m);
    for (int i = 0; i < SIZE; i++) begin
      if (ex[i]) acc = modmul(acc, sq, m);
      sq = modmul(sq, sq, m);
    end
    return acc;
  endfunction

  // Multiplier model: one request in flight, fixed or random latency.
  initial begin
    bit req_hs, res_hs, rst_s;
    logic [SIZE-1:0] a, bb, nn;
    bus.mm_tready     = 1'b0;
    bus.mm_res_tvalid = 1'b0;
    bus.mm_res_tdata  = '0;
    forever begin
      @(posedge clk);
      rst_s  = rst;
      req_hs = bus.mm_tvalid && bus.mm_tready;
      res_hs = bus.mm_res_tvalid && bus.mm_res_tready;
      a = bus.mm_a_tdata; bb = bus.mm_b_tdata; nn = bus.mm_n_tdata;
      #1;
      if (rst_s) begin
        pending = 1'b0;
        delay   = 0;
      end else begin
        if (res_hs) pending = 1'b0;
        if (req_hs) begin
          pending  = 1'b1;
          pend_res = modmul(a, bb, nn);
          last_sq  = (a == bb);
          delay    = rand_mm ? $urandom_range(0, 5) : 2;
          mm_reqs++;
        end else if (pending && delay > 0) begin
          delay--;
        end
      end
      bus.mm_res_tvalid = pending && (delay == 0);
      bus.mm_res_tdata  = pending ? pend_res : '0;
      bus.mm_tready     = !pending && (!rand_mm || ($urandom_range(0, 3) != 0));
    end
  end

  // in_tready must never be raised while an operation is in progress.
  initial begin
    forever begin
      @(posedge clk);
      if ((bus.busy || bus.out_tvalid) && bus.in_tready) rdy_viol++;
    end
  end

  task automatic launch(input logic [SIZE-1:0] base, input logic [SIZE-1:0] ex,
                        input logic [SIZE-1:0] m, input string tag);
    bit accepted;
    int unsigned cyc;
    bus.in_tdata_base = base;
    bus.in_tdata_exp  = ex;
    bus.in_tdata_mod  = m;
    bus.in_tvalid     = 1'b1;
    accepted = 1'b0;
    cyc = 0;
    while (!accepted && cyc < 100) begin
      @(posedge clk);
      accepted = bus.in_tready;
      cyc++;
    end
    #1;
    bus.in_tvalid = 1'b0;
    if (!accepted) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [SIZE-1:0] base,
                        input logic [SIZE-1:0] ex, input logic [SIZE-1:0] m,
                        input logic [SIZE-1:0] want, input bit want_err,
                        input int unsigned want_mm, input bit stall);
    int unsigned start_reqs;
    int unsigned cyc;
    int unsigned unstable;
    logic [SIZE-1:0] held;
    start_reqs = mm_reqs;
    launch(base, ex, m, tag);
    cyc = 0;
    while (!bus.out_tvalid && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!bus.out_tvalid) begin
      check({tag, "_result_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (stall) begin
      held = bus.out_tdata;
      unstable = 0;
      repeat (20) begin
        @(posedge clk);
        #1;
        if (!bus.out_tvalid || bus.out_tdata !== held || bus.in_tready) unstable++;
      end
      check({tag, "_stall_stable"}, 64'(unstable), 64'd0);
    end
    check({tag, "_data"}, bus.out_tdata, want);
    check({tag, "_error"}, 64'(bus.out_error), 64'(want_err));
    bus.out_tready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_tready = 1'b0;
    check({tag, "_mm_reqs"}, 64'(mm_reqs - start_reqs), 64'(want_mm));
    check({tag, "_outv_drop"}, 64'(bus.out_tvalid), 64'd0);
  endtask

  initial begin
    int unsigned cyc;
    rst = 1'b1;
    bus.in_tvalid     = 1'b0;
    bus.in_tdata_base = '0;
    bus.in_tdata_exp  = '0;
    bus.in_tdata_mod  = '0;
    bus.out_tready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_tready",  64'(bus.in_tready), 64'd0);
    check("rst_out_tvalid", 64'(bus.out_tvalid), 64'd0);
    check("rst_out_tdata",  bus.out_tdata, 64'd0);
    check("rst_out_error",  64'(bus.out_error), 64'd0);
    check("rst_mm_tvalid",  64'(bus.mm_tvalid), 64'd0);
    check("rst_mm_res_rdy", 64'(bus.mm_res_tready), 64'd0);
    check("rst_busy",       64'(bus.busy), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_tready", 64'(bus.in_tready), 64'd1);
    @(posedge clk);
    #1;

    // 13 = 1101b: 3 multiplies + 3 squares
    run_op("p4_13_497", 64'd4, 64'd13, 64'd497, 64'd445, 1'b0, 6, 1'b0);
    run_op("p3_0_7",    64'd3, 64'd0,  64'd7,   64'd1,   1'b0, 0, 1'b0);
    run_op("p3_5_1",    64'd3, 64'd5,  64'd1,   64'd0,   1'b0, 0, 1'b0);
    run_op("p10_1_7",   64'd10, 64'd1, 64'd7,   64'd3,   1'b0, 1, 1'b0);
    // 1234 = 234 (mod 1000); 234^2=756, ^4=536, ^8=296, ^10=296*756 -> 776
    run_op("p1234_10",  64'd1234, 64'd10, 64'd1000, 64'd776, 1'b0, 5, 1'b0);
    run_op("p2_10",     64'd2, 64'd10, 64'd1000, 64'd24, 1'b0, 5, 1'b0);
    run_op("mod0",      64'd3, 64'd5,  64'd0,   64'd0,   1'b1, 0, 1'b0);
    run_op("p5_3_13",   64'd5, 64'd3,  64'd13,  64'd8,   1'b0, 3, 1'b0);

    // Long exponent under random multiplier stalls and a held-off consumer.
    rand_mm = 1'b1;
    run_op("pbig", 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h1FFF_FFFF_FFFF_FFFF,
           gold(64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1FFF_FFFF_FFFF_FFFF),
           1'b0, 127, 1'b1);
    rand_mm = 1'b0;
    @(posedge clk);
    #1;

    // Reset while a square is outstanding.
    launch(64'd7, 64'd100, 64'd101, "p7_100_abort");
    cyc = 0;
    while (!(bus.mm_res_tready && last_sq) && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abort_reached_wait_sqr", 64'(bus.mm_res_tready && last_sq), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy",       64'(bus.busy), 64'd0);
    check("abort_mm_tvalid",  64'(bus.mm_tvalid), 64'd0);
    check("abort_out_tvalid", 64'(bus.out_tvalid), 64'd0);
    check("abort_in_tready",  64'(bus.in_tready), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // 100 = 1100100b: 3 multiplies + 6 squares
    run_op("p7_100_101", 64'd7, 64'd100, 64'd101, 64'd1, 1'b0, 9, 1'b0);

    check("in_tready_while_busy", 64'(rdy_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
